// File: rtl/lcd_pixel_feeder_if.sv
// Signals between the PPU pixel stream and the LCD framebuffer write port.
// The feeder sits on the slave side.
interface lcd_pixel_feeder_if;
  logic        ce;
  logic        pix_valid;
  logic [14:0] pix_data;
  logic [1:0]  mode;
  logic        on;
  logic        isGBC;
  logic        lcd_clkena;
  logic [14:0] lcd_data;
  logic [1:0]  lcd_mode;
  logic        lcd_on;
  logic        overflow;
  logic        short_frame;

  modport master (
    output ce, pix_valid, pix_data, mode, on, isGBC,
    input  lcd_clkena, lcd_data, lcd_mode, lcd_on, overflow, short_frame
  );

  modport slave (
    input  ce, pix_valid, pix_data, mode, on, isGBC,
    output lcd_clkena, lcd_data, lcd_mode, lcd_on, overflow, short_frame
  );
endinterface

// File: rtl/lcd_pixel_feeder.sv
// Buffers PPU pixels in a small FIFO and drains them to the LCD framebuffer at one per ce.
// It also withholds vblank until the FIFO has drained, and paints a white frame when the LCD is switched off.
module lcd_pixel_feeder #(
  parameter int DEPTH = 8,
  parameter int LCD_W = 160,
  parameter int LCD_H = 144
) (
  input logic               clk,
  input logic               reset,
  lcd_pixel_feeder_if.slave bus
);
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);
  localparam logic [14:0] FRAME_PIX = 15'(LCD_W * LCD_H);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_FILL_RST = 2'd1;
  localparam logic [1:0] ST_FILL     = 2'd2;
  localparam logic [1:0] ST_OFF      = 2'd3;

  localparam logic [1:0] MODE_VBLANK = 2'b01;
  localparam logic [1:0] MODE_XFER   = 2'b11;

  logic [1:0]  state;
  logic [14:0] fifo_mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [14:0] pix_cnt, fill_cnt;
  logic        on_d;

  logic        lcd_clkena_q, lcd_on_q, overflow_q, short_frame_q;
  logic [14:0] lcd_data_q;
  logic [1:0]  lcd_mode_q;

  logic        empty, full, on_rise, on_fall, push, pop, vblank_fwd;
  logic [14:0] white;

  always_comb begin
    empty      = (wr_ptr == rd_ptr);
    full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    on_rise    = bus.on && !on_d;
    on_fall    = on_d && !bus.on;
    push       = (state == ST_RUN) && !on_fall && bus.pix_valid && !full;
    pop        = (state == ST_RUN) && !on_fall && bus.ce && !empty;
    // Vblank may only reach the LCD once every queued pixel, including one arriving now, is written.
    vblank_fwd = (bus.mode == MODE_VBLANK) && (lcd_mode_q != MODE_VBLANK) && empty && !push;
    white      = bus.isGBC ? 15'h7FFF : 15'h0000;
  end

  // NOTE: FIFO storage is deliberately left out of reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= bus.pix_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_RUN;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      pix_cnt       <= '0;
      fill_cnt      <= '0;
      on_d          <= 1'b0;
      lcd_clkena_q  <= 1'b0;
      lcd_data_q    <= '0;
      lcd_mode_q    <= MODE_VBLANK;
      lcd_on_q      <= 1'b0;
      overflow_q    <= 1'b0;
      short_frame_q <= 1'b0;
    end else begin
      on_d         <= bus.on;
      lcd_clkena_q <= 1'b0;
      if (state != ST_RUN && on_rise) begin
        // Abort the white fill: one vblank clk restarts the LCD pointer for the fresh frame.
        state      <= ST_RUN;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        pix_cnt    <= '0;
        lcd_mode_q <= MODE_VBLANK;
        lcd_on_q   <= 1'b1;
      end else begin
        case (state)
          ST_RUN: begin
            if (on_fall) begin
              state      <= ST_FILL_RST;
              wr_ptr     <= '0;
              rd_ptr     <= '0;
              lcd_mode_q <= MODE_VBLANK;
              lcd_on_q   <= 1'b1;
            end else begin
              lcd_on_q <= bus.on;
              if (push) wr_ptr <= wr_ptr + PTR_ONE;
              if (pop) begin
                rd_ptr       <= rd_ptr + PTR_ONE;
                lcd_clkena_q <= 1'b1;
                lcd_data_q   <= fifo_mem[rd_ptr[AW-1:0]];
                // Saturating at FRAME_PIX means "a full frame was delivered".
                if (pix_cnt != FRAME_PIX) pix_cnt <= pix_cnt + 15'd1;
              end
              if (bus.pix_valid && full) overflow_q <= 1'b1;
              if (bus.mode != MODE_VBLANK) begin
                lcd_mode_q <= bus.mode;
              end else if (vblank_fwd) begin
                lcd_mode_q <= MODE_VBLANK;
                pix_cnt    <= '0;
                if (pix_cnt < FRAME_PIX) short_frame_q <= 1'b1;
              end
            end
          end
          ST_FILL_RST: begin
            state      <= ST_FILL;
            fill_cnt   <= '0;
            lcd_mode_q <= MODE_XFER;
            lcd_on_q   <= 1'b1;
          end
          ST_FILL: begin
            lcd_mode_q <= MODE_XFER;
            lcd_on_q   <= 1'b1;
            if (bus.ce) begin
              lcd_clkena_q <= 1'b1;
              lcd_data_q   <= white;
              fill_cnt     <= fill_cnt + 15'd1;
              if (fill_cnt == FRAME_PIX - 15'd1) state <= ST_OFF;
            end
          end
          default: begin
            // ST_OFF: DMG shows its lightest shade with the panel off; GBC must keep showing the white buffer.
            lcd_mode_q <= MODE_VBLANK;
            lcd_on_q   <= bus.isGBC;
          end
        endcase
      end
    end
  end

  assign bus.lcd_clkena  = lcd_clkena_q;
  assign bus.lcd_data    = lcd_data_q;
  assign bus.lcd_mode    = lcd_mode_q;
  assign bus.lcd_on      = lcd_on_q;
  assign bus.overflow    = overflow_q;
  assign bus.short_frame = short_frame_q;

endmodule
